// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 keypad scanner and its consumers.
// Contents: debounce state enum, key/matrix dimensions, key_legend() mapping an
// index (4*column + row) to the hex digit printed on the board keypad.
package keypad_pkg;

    typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;

    localparam int KEY_W = 4;
    localparam int ROWS  = 4;
    localparam int COLS  = 4;

    // Nibble i holds the legend of key index i; '*' is shown as E and '#' as F.
    localparam logic [63:0] LEGEND = 64'hDCBA_F963_0852_E741;

    function automatic logic [3:0] key_legend(input logic [KEY_W-1:0] index);
        return LEGEND[{index, 2'b00} +: 4];
    endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: per-scan press/release debouncer for the keypad scanner.
// Ports: clk, reset (sync, active-high); scan_end marks the last column tick of a
// scan, with cand_valid/cand giving that scan's lowest pressed key index;
// key (last accepted index), key_valid (one-cycle accept pulse), key_held.
module keypad_debounce
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_end,
    input  logic             cand_valid,
    input  logic [KEY_W-1:0] cand,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CW-1:0] TARGET = CW'(DEBOUNCE_SCANS);
    localparam logic [CW-1:0] ONE    = CW'(1);

    state_t           state;
    logic [CW-1:0]    stab_cnt;
    logic [CW-1:0]    cnt_next;
    logic [KEY_W-1:0] latched;
    logic             same;

    assign cnt_next = (stab_cnt == TARGET) ? stab_cnt : stab_cnt + 1'b1;
    // latched is the key being debounced, or the accepted key while PRESSED/RELEASE
    assign same = cand_valid && cand == latched;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            stab_cnt  <= '0;
            latched   <= '0;
            key       <= '0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            if (scan_end) begin
                case (state)
                    IDLE:
                        if (cand_valid) begin
                            latched  <= cand;
                            stab_cnt <= ONE;
                            if (TARGET == ONE) begin
                                state     <= PRESSED;
                                key       <= cand;
                                key_valid <= 1'b1;
                                key_held  <= 1'b1;
                            end else begin
                                state <= DEBOUNCE;
                            end
                        end
                    DEBOUNCE:
                        if (!cand_valid) begin
                            state <= IDLE;
                        end else if (!same) begin
                            latched  <= cand;
                            stab_cnt <= ONE;
                        end else if (cnt_next == TARGET) begin
                            state     <= PRESSED;
                            stab_cnt  <= cnt_next;
                            key       <= latched;
                            key_valid <= 1'b1;
                            key_held  <= 1'b1;
                        end else begin
                            stab_cnt <= cnt_next;
                        end
                    PRESSED:
                        if (!same) begin
                            // a single clean scan already satisfies a one-scan release
                            if (!cand_valid && TARGET == ONE) begin
                                state    <= IDLE;
                                key_held <= 1'b0;
                            end else begin
                                state    <= RELEASE;
                                stab_cnt <= ONE;
                            end
                        end
                    RELEASE:
                        if (same) begin
                            state <= PRESSED;
                        end else if (cand_valid) begin
                            state    <= DEBOUNCE;
                            latched  <= cand;
                            stab_cnt <= ONE;
                            key_held <= 1'b0;
                        end else if (cnt_next == TARGET) begin
                            state    <= IDLE;
                            key_held <= 1'b0;
                        end else begin
                            stab_cnt <= cnt_next;
                        end
                    default:
                        state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// keypad_scanner: strobes a 4x4 key matrix one column at a time and debounces the result.
// Ports: clk, reset (sync, active-high); row (active-low, asynchronous);
// col (active-low one-cold strobe); key (accepted index 4*column + row),
// key_valid (one-cycle pulse on a new press), key_held (high until release accepted).
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_PERIOD    = 100000,
    parameter int DEBOUNCE_SCANS = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [ROWS-1:0]  row,
    output logic [COLS-1:0]  col,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             key_held
);

    localparam int DW = $clog2(SCAN_PERIOD);

    logic [ROWS-1:0]  sync_a;
    logic [ROWS-1:0]  sync_b;
    logic [DW-1:0]    dwell;
    logic [1:0]       col_idx;
    logic             acc_valid;
    logic [KEY_W-1:0] acc_cand;
    logic             tick;
    logic             scan_end;
    logic             hit;
    logic [1:0]       hit_row;
    logic             cand_valid;
    logic [KEY_W-1:0] cand;

    assign tick     = dwell == DW'(SCAN_PERIOD - 1);
    assign scan_end = tick && col_idx == 2'd3;
    assign hit      = ~&sync_b;
    assign hit_row  = !sync_b[0] ? 2'd0 : !sync_b[1] ? 2'd1 : !sync_b[2] ? 2'd2 : 2'd3;
    // an earlier column always wins, so the scan yields the lowest pressed index
    assign cand_valid = acc_valid || hit;
    assign cand       = acc_valid ? acc_cand : {col_idx, hit_row};

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_a    <= '1;
            sync_b    <= '1;
            dwell     <= '0;
            col_idx   <= '0;
            col       <= {{(COLS-1){1'b1}}, 1'b0};
            acc_valid <= 1'b0;
            acc_cand  <= '0;
        end else begin
            sync_a <= row;
            sync_b <= sync_a;
            dwell  <= tick ? '0 : dwell + 1'b1;
            if (tick) begin
                col_idx   <= col_idx + 2'd1;
                col       <= {col[COLS-2:0], col[COLS-1]};
                acc_valid <= !scan_end && cand_valid;
                acc_cand  <= scan_end ? '0 : cand;
            end
        end
    end

    keypad_debounce #(.DEBOUNCE_SCANS(DEBOUNCE_SCANS)) u_debounce (
        .clk       (clk),
        .reset     (reset),
        .scan_end  (scan_end),
        .cand_valid(cand_valid),
        .cand      (cand),
        .key       (key),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

endmodule

// File: doc/keypad_scanner.md
# keypad_scanner

Scans a 4x4 passive key matrix by strobing one column at a time and reading the four row lines, then debounces the result. It emits a key index with a one-cycle valid pulse and a held flag. It is the input-side counterpart of the time-multiplexed display driver: same one-cold strobe rotation, opposite signal direction. The block sits between the keypad pins and the game/control logic.

## Interface
- SCAN_PERIOD, 100000: clk cycles each column is strobed before its rows are sampled; minimum 4.
- DEBOUNCE_SCANS, 4: consecutive full scans a condition must hold before a press or release is accepted; minimum 1.
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- row  in  4  matrix row lines, active-low (board pull-ups); asynchronous to clk
- col  out  4  column strobes, active-low one-cold; col[i] low drives column i
- key  out  4  index of the accepted key, 4*column + row
- key_valid  out  1  one-cycle pulse when a new press is accepted; key is valid in the same cycle
- key_held  out  1  high from acceptance until the release is accepted

## Operation
- row passes through a 2-flop synchronizer. Only the synchronized value is used.
- Dwell counter runs 0..SCAN_PERIOD-1. Terminal count is the "tick".
- On a tick, the synchronized row is sampled for the current column, and the column then advances 0→1→2→3→0.
- Within a full scan (columns 0..3), the candidate is the first low row in scan order: lowest column, then lowest row. Simultaneous keys therefore resolve to the lowest index. "None" means no low row in all four columns.
- At the column-3 tick (scan end), the candidate is evaluated by the FSM; the scan accumulator then clears. stab_cnt counts scans.
- IDLE: candidate present → DEBOUNCE, latch cand, stab_cnt=1. If DEBOUNCE_SCANS=1, go straight to the accept action instead.
- DEBOUNCE:
  - Same candidate → stab_cnt+1. On reaching DEBOUNCE_SCANS → PRESSED, key<=cand, key_valid pulse, key_held=1.
  - Different candidate → restart with the new candidate, stab_cnt=1.
  - None → IDLE.
- PRESSED:
  - Same candidate → stay.
  - None or a different candidate → RELEASE, stab_cnt=1.
- RELEASE:
  - None → stab_cnt+1. On reaching DEBOUNCE_SCANS → IDLE, key_held=0.
  - Original key returns → PRESSED, with no new key_valid (bounce).
  - Different key → DEBOUNCE with that key, stab_cnt=1; key_held drops to 0.
- key holds the last accepted index until the next acceptance. It does not clear on release.
- stab_cnt saturates and is sized $clog2(DEBOUNCE_SCANS+1).

## Timing
- Reset values: col=4'b1110, key=0, key_valid=0, key_held=0, dwell=0, column index=0, state IDLE, synchronizer=4'b1111, scan accumulator cleared.
- Column changes on the clk edge after its tick. Each column is low for exactly SCAN_PERIOD cycles, so a full scan is 4*SCAN_PERIOD cycles.
- The row sample at a tick reflects the pins ≥2 cycles earlier. This gives SCAN_PERIOD-2 cycles of settling after the strobe.
- key_valid and key update one cycle after the scan-end tick of the DEBOUNCE_SCANS-th stable scan.
- A clean press present from reset produces key_valid at cycle 1 + 4*SCAN_PERIOD*DEBOUNCE_SCANS (+2 synchronizer), counted from reset deassertion.
- key_valid is never asserted in two consecutive cycles.
- Reset asserted mid-scan or mid-debounce returns everything to reset values on the next edge. No partial key is reported.

## Structure
- Shared package keypad_pkg holds:
  - state enum {IDLE, DEBOUNCE, PRESSED, RELEASE}
  - KEY_W=4 and the constants ROWS=4, COLS=4
  - function key_legend(index) → hex digit for the board keypad layout, used by consumers rather than this block
- One sub-module, keypad_debounce, contains the FSM and stab_cnt. It takes scan_end, cand_valid and cand, and produces key, key_valid and key_held.
- The top level holds the dwell counter, column rotation, synchronizer and candidate capture.

## Test plan
All scenarios use SCAN_PERIOD=4 and DEBOUNCE_SCANS=2.
- Reset, no keys:
  - col cycles 1110→1101→1011→0111 every 4 cycles.
  - key_valid stays 0 for 200 cycles, and key=0.
- Hold key col2,row1 (row[1] pulled low while col[2] is low) steady:
  - exactly one key_valid pulse with key=9.
  - key_held=1 until release, then 0 two scans later.
- Bounce: toggle the press every 3 cycles for 40 cycles, then hold:
  - no key_valid during the bounce.
  - a single pulse with key=9 after 2 stable scans.
- Simultaneous col1,row3 and col0,row2 held:
  - key=2 (lowest index) and one pulse.
  - releasing only index 2 while index 7 stays held gives RELEASE→DEBOUNCE, then a pulse with key=7.
- Release glitch: while PRESSED, drop the key for one scan, then restore it:
  - key_held stays 1 throughout (RELEASE→PRESSED) with no second key_valid.
- Assert reset mid-DEBOUNCE of key 5:
  - next cycle shows col=1110, key_held=0 and no key_valid.
  - holding key 5 afterwards yields a pulse only after 2 full scans.
